scan_chain_ctrl: RTL
====================

SCAN_CHAIN_CTRL -- requirements
Module: scan_chain_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, meaning the length of the controlled scan chain in bits (minimum 2).
REQ-002 SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset; synchronous and active-high.
REQ-004 SHALL have port start, input, 1, a request to begin one scan operation; sampled only in IDLE.
REQ-005 SHALL have port capture, input, 1, sampled with start; 1 = parallel-capture before shifting.
REQ-006 SHALL have port pattern, input, WIDTH, the word to shift into the chain; sampled with start.
REQ-007 SHALL have port sr_enable, output, 1, the parallel-load enable to the shift register.
REQ-008 SHALL have port sr_scan_enable, output, 1, the shift enable to the shift register.
REQ-009 SHALL have port sr_scan_in, output, 1, the serial data to the shift register.
REQ-010 SHALL have port sr_scan_out, input, 1, the shift register MSB (its serial output).
REQ-011 SHALL have port result, output, WIDTH, the word unloaded from the chain.
REQ-012 SHALL have port busy, output, 1, high in every state except IDLE.
REQ-013 SHALL have port done, output, 1, a one-cycle pulse when result becomes valid.

Function
REQ-014 SHALL implement states IDLE, CAPTURE, SHIFT and DONE.
REQ-015 IDLE with start=1 SHALL latch pattern and capture; next state SHALL be CAPTURE if capture=1, else SHIFT.
REQ-016 CAPTURE SHALL last exactly 1 cycle, assert sr_enable=1 and sr_scan_enable=0, then go to SHIFT.
REQ-017 SHIFT SHALL last exactly WIDTH cycles with sr_scan_enable=1 and sr_enable=0.
REQ-018 In SHIFT cycle i (0..WIDTH-1), sr_scan_in SHALL equal latched pattern[WIDTH-1-i] (MSB first).
REQ-019 Each SHIFT cycle SHALL sample sr_scan_out into an internal unload register, shifting left (LSB in); after WIDTH cycles it holds the pre-shift chain contents, with the original MSB at result[WIDTH-1].
REQ-020 The bit counter SHALL be $clog2(WIDTH) bits wide; SHIFT SHALL exit when count==WIDTH-1, with no wrap into an extra cycle.
REQ-021 On SHIFT exit, result SHALL be updated from the unload register; DONE SHALL then assert done=1 for 1 cycle and return to IDLE.
REQ-022 result SHALL hold its value until the next DONE or reset.
REQ-023 Latency from the start-sampling edge to done high SHALL be WIDTH+2 cycles with capture, WIDTH+1 without.
REQ-024 start in CAPTURE/SHIFT/DONE SHALL be ignored, not queued; pattern and capture changes mid-operation SHALL have no effect.
REQ-025 sr_enable and sr_scan_enable SHALL never be high in the same cycle.
REQ-026 In IDLE and DONE, sr_enable, sr_scan_enable and sr_scan_in SHALL be 0.

Reset
REQ-027 rst=1 SHALL force IDLE and clear the counter, latched pattern, unload register and result to 0 on the next edge.
REQ-028 After reset, busy, done, sr_enable, sr_scan_enable and sr_scan_in SHALL be 0.
REQ-029 Reset mid-operation SHALL abort it without pulsing done; rst SHALL dominate a simultaneous start.

Structure
REQ-030 The state enum (IDLE, CAPTURE, SHIFT, DONE) SHALL live in shared package scan_ctrl_pkg.
REQ-031 A sub-module scan_bit_counter (clear, inc, terminal-count flag at WIDTH-1) is natural; all else SHALL be in scan_chain_ctrl.
REQ-032 All outputs SHALL be registered or decoded from state only, with no combinational path from start to any sr_* output.

Verification (WIDTH=8, controller connected to an 8-bit parallel-load/scan shift register)
REQ-033 Capture and exchange: shift-register data_in=0xA5, start with capture=1 and pattern=0x3C -> done 10 cycles later; result=0xA5; chain holds 0x3C.
REQ-034 Shift only: chain preloaded 0x81, start with capture=0 and pattern=0xFF -> done 9 cycles later; result=0x81; chain holds 0xFF.
REQ-035 Back-to-back: start held high for 30 cycles with pattern=0x5A -> operations separated by 1 IDLE cycle; second result=0x5A.
REQ-036 Busy start: a start pulse during SHIFT cycle 3 -> ignored; exactly 1 done pulse.
REQ-037 Reset mid-SHIFT: rst at SHIFT cycle 4 -> next cycle is IDLE; busy=0; result=0x00; no done pulse.
REQ-038 Exclusivity assertion: sr_enable & sr_scan_enable is never 1 in any scenario.

Source files
------------

// File: rtl/scan_ctrl_pkg.sv
// Shared definitions for the scan-chain controller.
// Contents:
//   scan_state_e : controller states IDLE -> (CAPTURE) -> SHIFT -> DONE
package scan_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        SHIFT   = 2'd2,
        DONE    = 2'd3
    } scan_state_e;

endpackage : scan_ctrl_pkg

// File: rtl/scan_chain_ctrl_if.sv
// Bundle of the request and shift-register signals of scan_chain_ctrl.
// Ports (signals):
//   start, capture, pattern[WIDTH] : operation request from the requester
//   sr_enable, sr_scan_enable      : parallel-load / shift enables to the chain
//   sr_scan_in                     : serial data into the chain
//   sr_scan_out                    : chain MSB (serial data out of the chain)
//   result[WIDTH], busy, done      : unloaded word and status
// Modports:
//   master : requester side, which also owns the shift register
//   slave  : the controller
interface scan_chain_ctrl_if #(
    parameter int WIDTH = 8
);

    logic             start;
    logic             capture;
    logic [WIDTH-1:0] pattern;
    logic             sr_enable;
    logic             sr_scan_enable;
    logic             sr_scan_in;
    logic             sr_scan_out;
    logic [WIDTH-1:0] result;
    logic             busy;
    logic             done;

    modport master (
        output start, capture, pattern, sr_scan_out,
        input  sr_enable, sr_scan_enable, sr_scan_in, result, busy, done
    );

    modport slave (
        input  start, capture, pattern, sr_scan_out,
        output sr_enable, sr_scan_enable, sr_scan_in, result, busy, done
    );

endinterface : scan_chain_ctrl_if

// File: rtl/scan_bit_counter.sv
// Bit counter for the SHIFT phase.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   clear    : return count to 0 (wins over inc)
//   inc      : advance count by one
//   terminal : high while count == WIDTH-1
module scan_bit_counter #(
    parameter int WIDTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    input  logic inc,
    output logic terminal
);

    localparam int CW = $clog2(WIDTH);

    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            count_q <= '0;
        end else if (inc) begin
            count_q <= count_q + CW'(1);
        end
    end

    assign terminal = (count_q == CW'(WIDTH - 1));

endmodule : scan_bit_counter

// File: rtl/scan_chain_ctrl.sv
// Scan-chain controller: optionally parallel-captures the chain, then shifts
// a latched pattern in MSB first while unloading the previous chain contents
// into result.
// Ports:
//   clk, rst : clock, synchronous active-high reset
//   ctl      : scan_chain_ctrl_if.slave (start/capture/pattern request,
//              sr_* shift-register controls, result/busy/done status)
module scan_chain_ctrl
    import scan_ctrl_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    scan_chain_ctrl_if.slave   ctl
);

    scan_state_e      state_q, state_d;
    logic [WIDTH-1:0] pattern_q;
    logic [WIDTH-1:0] unload_q;
    logic [WIDTH-1:0] unload_d;
    logic [WIDTH-1:0] result_q;
    logic             last_bit;

    // The counter is held clear outside SHIFT and on the exit edge, so it
    // never advances into a WIDTH+1-th cycle.
    scan_bit_counter #(
        .WIDTH (WIDTH)
    ) u_bit_counter (
        .clk      (clk),
        .rst      (rst),
        .clear    ((state_q != SHIFT) || last_bit),
        .inc      (state_q == SHIFT),
        .terminal (last_bit)
    );

    // Chain MSB comes out first, so shifting left puts it at result[WIDTH-1].
    assign unload_d = {unload_q[WIDTH-2:0], ctl.sr_scan_out};

    always_comb begin
        // NOTE: every output of this block gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (ctl.start) state_d = ctl.capture ? CAPTURE : SHIFT;
            CAPTURE: state_d = SHIFT;
            SHIFT:   if (last_bit) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: the data registers are cleared by reset too, not just the
        // state, so an aborted operation leaves result at 0.
        if (rst) begin
            state_q   <= IDLE;
            pattern_q <= '0;
            unload_q  <= '0;
            result_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments, so every register here sees the
            // pre-edge value of the others regardless of statement order.
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (ctl.start) pattern_q <= ctl.pattern;
                end
                SHIFT: begin
                    // The pattern is consumed MSB first by shifting it left.
                    pattern_q <= {pattern_q[WIDTH-2:0], 1'b0};
                    unload_q  <= unload_d;
                    if (last_bit) result_q <= unload_d;
                end
                default: ;
            endcase
        end
    end

    // Shift-register controls are decoded from registered state only, so
    // start has no combinational path to any sr_* output.
    always_comb begin
        ctl.sr_enable      = 1'b0;
        ctl.sr_scan_enable = 1'b0;
        ctl.sr_scan_in     = 1'b0;
        unique case (state_q)
            CAPTURE: ctl.sr_enable = 1'b1;
            SHIFT: begin
                ctl.sr_scan_enable = 1'b1;
                ctl.sr_scan_in     = pattern_q[WIDTH-1];
            end
            default: ;
        endcase
    end

    assign ctl.busy   = (state_q != IDLE);
    assign ctl.done   = (state_q == DONE);
    assign ctl.result = result_q;

endmodule : scan_chain_ctrl
